// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped 32-bit down-counting timer with prescaler and
// level interrupt, sitting on the SoC's external iomem bus.
//
// Ports:
//   clk          sole clock, all state changes on its rising edge
//   reset        synchronous, active-high
//   iomem_valid  bus request from the SoC
//   iomem_ready  one-cycle completion pulse for accesses inside this window
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  registered read data, valid while iomem_ready is high
//   irq_out      level interrupt (EXP & IRQ_EN), intended for irq_5
//
// Register map (offset from BASE_ADDR):
//   0x0 CTRL   [0] EN, [1] AUTO, [2] IRQ_EN, [16 +: PRESCALE_W] PRESC
//   0x4 LOAD   reload value
//   0x8 COUNT  live counter; a write loads it directly
//   0xC STATUS [0] EXP, sticky, write-1-to-clear
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);

    localparam int unsigned PW         = PRESCALE_W;
    localparam int unsigned PRESC_LSB  = 16;
    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_LOAD   = 2'd1;
    localparam logic [1:0]  REG_COUNT  = 2'd2;
    localparam logic [1:0]  REG_STATUS = 2'd3;

    // Architectural state
    logic          en_q, auto_q, irq_en_q, exp_q;
    logic [PW-1:0] presc_q, pcnt_q;
    logic [31:0]   load_q, count_q;

    // Next-state values
    logic          en_d, auto_d, irq_en_d, exp_d;
    logic [PW-1:0] presc_d, pcnt_d;
    logic [31:0]   load_d, count_d;

    logic        sel, access, wr_en;
    logic [1:0]  reg_idx;
    logic        tick, expire, clr_exp;
    logic [31:0] ctrl_word, ctrl_wr, rd_word;

    // Apply byte strobes to a 32-bit register image
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Bus decode: one access per transaction, taken in the cycle before ready
    always_comb begin
        sel     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
        access  = sel && !iomem_ready;
        wr_en   = access && (iomem_wstrb != 4'd0);
        reg_idx = iomem_addr[3:2];
    end

    // Register images and read mux
    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[0]              = en_q;
        ctrl_word[1]              = auto_q;
        ctrl_word[2]              = irq_en_q;
        ctrl_word[PRESC_LSB +: PW] = presc_q;

        rd_word = '0;
        case (reg_idx)
            REG_CTRL:   rd_word = ctrl_word;
            REG_LOAD:   rd_word = load_q;
            REG_COUNT:  rd_word = count_q;
            REG_STATUS: rd_word = {31'd0, exp_q};
            default:    rd_word = '0;
        endcase
    end

    // Timer next-state: prescaler, tick, expiry, then bus writes override
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        presc_d  = presc_q;
        load_d   = load_q;
        count_d  = count_q;
        pcnt_d   = pcnt_q;
        ctrl_wr  = ctrl_word;
        clr_exp  = 1'b0;

        tick   = en_q && (pcnt_q == presc_q);
        expire = tick && (count_q == 32'd0);

        if (!en_q || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end

        // A bus write to CTRL or COUNT replaces whatever the tick did
        if (wr_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    ctrl_wr  = merge_bytes(ctrl_word, iomem_wdata, iomem_wstrb);
                    en_d     = ctrl_wr[0];
                    auto_d   = ctrl_wr[1];
                    irq_en_d = ctrl_wr[2];
                    presc_d  = ctrl_wr[PRESC_LSB +: PW];
                end
                REG_LOAD:   load_d  = merge_bytes(load_q, iomem_wdata, iomem_wstrb);
                REG_COUNT:  count_d = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
                REG_STATUS: clr_exp = iomem_wstrb[0] && iomem_wdata[0];
                default: ;
            endcase
        end

        // Expiry beats a simultaneous clear
        exp_d = (exp_q && !clr_exp) || expire;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            auto_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            exp_q       <= 1'b0;
            presc_q     <= '0;
            pcnt_q      <= '0;
            load_q      <= '0;
            count_q     <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq_out     <= 1'b0;
        end else begin
            en_q        <= en_d;
            auto_q      <= auto_d;
            irq_en_q    <= irq_en_d;
            exp_q       <= exp_d;
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
            load_q      <= load_d;
            count_q     <= count_d;
            iomem_ready <= access;
            if (access) begin
                iomem_rdata <= rd_word;
            end
            // Registered from next-state so irq follows EXP/IRQ_EN with no lag
            irq_out     <= exp_d && irq_en_d;
        end
    end

    // Address byte offset and non-field CTRL bits are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, iomem_addr[1:0], ctrl_wr};

endmodule
